// File: rtl/uart_pkg.sv
// Shared types and constants for the serial register-write receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam int   WIRE_ADDR_W = 6;
    localparam logic FIRST_MARK  = 1'b0;
    localparam logic SECOND_MARK = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with exact occupancy count.
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == {LVL_W{1'b0}});
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_rx.sv
// Oversampled UART receiver pairing two bytes into address/data register writes.
module uart_reg_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 6,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_clk,
    input  logic                          rx,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [7:0]                    wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          seq_err,
    output logic                          ovf_err,
    input  logic                          err_clr
);
    localparam int         ENT_W     = ADDR_W + DATA_BITS;
    localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_FULL = 4'(OVERSAMPLE - 1);

    logic             r_sync1, r_sync2, r_prev;
    rx_state_t        r_state, w_state_nxt;
    logic [3:0]       r_tick;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [6:0]       r_hold;
    logic             r_hold_vld;
    logic             r_frame_err, r_seq_err, r_ovf_err;
    logic             w_fall, w_tick_clr, w_tick_inc, w_start_ok, w_shift_en;
    logic             w_byte_ok, w_stop_bad;
    logic             w_push, w_seq_set, w_ovf_set, w_pop;
    logic             w_fifo_full, w_fifo_empty;
    logic [ENT_W-1:0] w_push_data, w_head;

    assign w_fall = r_prev & ~r_sync2;

    // Two-flop synchroniser for the asynchronous rx pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-tick strobes; nothing moves without a uart_clk tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_clr  = 1'b0;
        w_tick_inc  = 1'b0;
        w_start_ok  = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        if (uart_clk) begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = START;
                        w_tick_clr  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                START: begin
                    if (r_tick == TICK_HALF) begin
                        w_tick_clr  = 1'b1;
                        w_start_ok  = ~r_sync2;
                        w_state_nxt = r_sync2 ? IDLE : DATA;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (r_tick == TICK_FULL) begin
                        w_tick_clr  = 1'b1;
                        w_shift_en  = 1'b1;
                        w_state_nxt = (r_bit_idx == 3'd7) ? STOP : DATA;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (r_tick == TICK_FULL) begin
                        w_tick_clr  = 1'b1;
                        w_byte_ok   = r_sync2;
                        w_stop_bad  = ~r_sync2;
                        w_state_nxt = r_sync2 ? IDLE : WAIT_IDLE;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (r_sync2) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Tick counter, bit index, LSB-first shifter and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= 1'b1;
            r_tick    <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else if (uart_clk) begin
            r_prev <= r_sync2;
            if (w_tick_clr) begin
                r_tick <= 4'd0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + 4'd1;
            end else begin
                r_tick <= r_tick;
            end
            if (w_shift_en) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else if (w_start_ok) begin
                r_bit_idx <= 3'd0;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
        end else begin
            r_prev <= r_prev;
        end
    end

    assign w_push      = w_byte_ok & (r_shift[7] == SECOND_MARK) & r_hold_vld;
    assign w_seq_set   = w_byte_ok & (r_shift[7] == SECOND_MARK) & ~r_hold_vld;
    assign w_push_data = {r_shift[ADDR_W:1], r_shift[0], r_hold};
    assign w_pop       = ~w_fifo_empty & wr_ready;
    assign w_ovf_set   = w_push & w_fifo_full & ~w_pop;

    // First-byte hold and sticky error flags; a same-cycle set beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= 7'd0;
            r_hold_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            r_seq_err   <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            if (w_byte_ok && (r_shift[7] == FIRST_MARK)) begin
                r_hold     <= r_shift[6:0];
                r_hold_vld <= 1'b1;
            end else if (w_push) begin
                r_hold_vld <= 1'b0;
            end else begin
                r_hold_vld <= r_hold_vld;
            end
            r_frame_err <= w_stop_bad | (r_frame_err & ~err_clr);
            r_seq_err   <= w_seq_set  | (r_seq_err   & ~err_clr);
            r_ovf_err   <= w_ovf_set  | (r_ovf_err   & ~err_clr);
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_level (fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign wr_valid             = ~w_fifo_empty;
    assign {wr_addr, wr_data}   = w_head;
    assign frame_err            = r_frame_err;
    assign seq_err              = r_seq_err;
    assign ovf_err              = r_ovf_err;

endmodule

// File: tb/tb_uart_reg_rx.sv
// Scoreboard bench for uart_reg_rx: serial frames in, expected writes queued and matched on handshake.
module tb_uart_reg_rx;
    localparam int OS = 6;
    localparam int AW = 6;
    localparam int FD = 4;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst_n, uart_clk, rx, wr_ready, err_clr;
    logic          wr_valid, frame_err, seq_err, ovf_err;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [LW-1:0] fifo_level;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [AW+7:0]     exp_q [$];
    logic [AW+7:0]     mon_e;
    logic [15:0]       pr;

    uart_reg_rx #(.OVERSAMPLE(OS), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_clk   (uart_clk),
        .rx         (rx),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .seq_err    (seq_err),
        .ovf_err    (ovf_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop side of the scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_beat", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 32'(wr_addr), 32'(mon_e[AW+7:8]));
                check_eq("wr_data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [AW-1:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // First byte carries data[6:0]; second carries {1, addr, data[7]}.
    function automatic logic [15:0] enc_pair(input logic [5:0] a, input logic [7:0] d);
        return {1'b0, d[6:0], 1'b1, a, d[7]};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(wr_valid), 32'd0);
        check_eq({tag, "_level"}, 32'(fifo_level), 32'd0);
        check_eq({tag, "_addr"},  32'(wr_addr), 32'd0);
        check_eq({tag, "_data"},  32'(wr_data), 32'd0);
        check_eq({tag, "_ferr"},  32'(frame_err), 32'd0);
        check_eq({tag, "_serr"},  32'(seq_err), 32'd0);
        check_eq({tag, "_oerr"},  32'(ovf_err), 32'd0);
    endtask

    // One frame: start, 8 data bits LSB first, stop; optional reset mid-bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1, input int rst_bit = -1);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == rst_bit) begin
                rx = fr[i];
                tick_wait(OS / 2);
                rst_n = 1'b0;
                rx    = 1'b1;
                #1;
                check_all_zero("midframe_rst");
                tick_wait(3);
                rst_n = 1'b1;
                return;
            end
            rx = fr[i];
            tick_wait(OS);
        end
    endtask

    task automatic send_pair(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick_wait(1);
        err_clr = 1'b0;
        tick_wait(1);
    endtask

    initial begin
        rst_n = 1'b0; uart_clk = 1'b1; rx = 1'b1; wr_ready = 1'b1; err_clr = 1'b0;
        tick_wait(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick_wait(4);

        // Basic pair
        expect_beat(6'h05, 8'hA5);
        send_byte(8'h25); send_byte(8'h8B);
        tick_wait(10);
        check_eq("t1_sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t1_ferr", 32'(frame_err), 32'd0);
        check_eq("t1_serr", 32'(seq_err), 32'd0);
        check_eq("t1_oerr", 32'(ovf_err), 32'd0);

        // Framing error, then a clean pair
        send_byte(8'h25, 1'b0);
        rx = 1'b1;
        tick_wait(2 * OS);
        check_eq("t2_ferr_set", 32'(frame_err), 32'd1);
        expect_beat(6'h05, 8'hA5);
        send_byte(8'h25); send_byte(8'h8B);
        tick_wait(10);
        check_eq("t2_sb_drained", 32'(exp_q.size()), 32'd0);
        pulse_clr();
        check_eq("t2_ferr_clr", 32'(frame_err), 32'd0);

        // Lone second byte
        send_byte(8'h81);
        tick_wait(10);
        check_eq("t3_serr_set", 32'(seq_err), 32'd1);
        check_eq("t3_level", 32'(fifo_level), 32'd0);
        expect_beat(6'h00, 8'hFF);
        send_byte(8'h7F); send_byte(8'h81);
        tick_wait(10);
        check_eq("t3_sb_drained", 32'(exp_q.size()), 32'd0);
        pulse_clr();

        // Overflow with stalled consumer
        wr_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pr = enc_pair(6'(k), 8'(k));
            if (k <= FD) expect_beat(6'(k), 8'(k));
            send_pair(pr);
        end
        tick_wait(4);
        check_eq("t4_level_full", 32'(fifo_level), 32'(FD));
        check_eq("t4_oerr_set", 32'(ovf_err), 32'd1);
        check_eq("t4_valid", 32'(wr_valid), 32'd1);
        wr_ready = 1'b1;
        tick_wait(10);
        check_eq("t4_sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t4_level_empty", 32'(fifo_level), 32'd0);
        pulse_clr();
        check_eq("t4_oerr_clr", 32'(ovf_err), 32'd0);

        // Start glitch, then a break
        rx = 1'b0;
        tick_wait(2);
        rx = 1'b1;
        tick_wait(20);
        check_eq("t5_glitch_ferr", 32'(frame_err), 32'd0);
        check_eq("t5_glitch_serr", 32'(seq_err), 32'd0);
        check_eq("t5_glitch_level", 32'(fifo_level), 32'd0);
        rx = 1'b0;
        tick_wait(12 * OS);
        rx = 1'b1;
        tick_wait(2 * OS);
        check_eq("t5_break_ferr", 32'(frame_err), 32'd1);
        check_eq("t5_break_serr", 32'(seq_err), 32'd0);
        expect_beat(6'h12, 8'h3C);
        send_pair(enc_pair(6'h12, 8'h3C));
        tick_wait(10);
        check_eq("t5_sb_drained", 32'(exp_q.size()), 32'd0);
        pulse_clr();

        // Reset in the middle of a second byte
        wr_ready = 1'b0;
        send_pair(enc_pair(6'h03, 8'h44));
        send_byte(8'h81);
        tick_wait(4);
        check_eq("t6_pre_valid", 32'(wr_valid), 32'd1);
        check_eq("t6_pre_serr", 32'(seq_err), 32'd1);
        send_byte(8'h33);
        send_byte(8'h8B, 1'b1, 5);
        rx = 1'b1;
        wr_ready = 1'b1;
        tick_wait(10);
        send_byte(8'h81);
        tick_wait(10);
        check_eq("t6_hold_cleared", 32'(seq_err), 32'd1);
        pulse_clr();
        expect_beat(6'h05, 8'hA5);
        send_byte(8'h25); send_byte(8'h8B);
        tick_wait(10);
        check_eq("t6_sb_drained", 32'(exp_q.size()), 32'd0);
        check_eq("t6_ferr", 32'(frame_err), 32'd0);
        check_eq("t6_serr", 32'(seq_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_reg_rx.md
Name: uart_reg_rx

Overview:
- Parametrised next-generation serial register-write receiver; sits between the async `rx` pin and the register file / APU write port.
- Oversampled UART receiver with start-glitch rejection, stop-bit framing check, and two-byte address/data pairing.
- Adds sticky error flags and a small output FIFO with valid/ready handshake, so back-to-back writes are not lost while the consumer is busy.

Parameters:
- OVERSAMPLE, 6: `uart_clk` ticks per bit. Legal range 4..15.
- ADDR_W, 4: output address width. Legal range 1..6. Takes A[ADDR_W-1:0] of the 6-bit wire address.
- FIFO_DEPTH, 4: write-FIFO entries. Power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- uart_clk  in  1  clock enable, one `clk` cycle per tick, rate OVERSAMPLE x baud
- rx  in  1  asynchronous serial input, idle high
- wr_valid  out  1  FIFO not empty
- wr_ready  in  1  consumer accepts head entry
- wr_addr  out  ADDR_W  head entry address
- wr_data  out  8  head entry data
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_err  out  1  sticky: a stop bit was sampled low
- seq_err  out  1  sticky: a second byte arrived with no first byte held
- ovf_err  out  1  sticky: a completed pair was dropped because the FIFO was full
- err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset values: all outputs 0, FIFO empty, hold empty, FSM in IDLE. Both sync flops and the previous-rx register reset to 1.
- All receive logic advances only on `clk` edges where `uart_clk`=1. FIFO pop and `err_clr` act on every `clk` edge.
- rx path: 2-flop synchroniser, then a previous-sample register for falling-edge detection.
- FSM (uart_pkg::rx_state_t):
  - IDLE: on a synced falling edge, clear the tick counter and go to START.
  - START: after OVERSAMPLE/2 ticks, sample. If low, go to DATA with bit_idx=0. If high, the start was a glitch; return to IDLE with no error.
  - DATA: sample every OVERSAMPLE ticks, 8 bits LSB first. After bit 7, go to STOP.
  - STOP: sample after OVERSAMPLE ticks.
    - High: the byte is valid; go to IDLE.
    - Low: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synced rx=1, then go to IDLE. This covers break conditions.
- Pairing, applied at the STOP-valid tick:
  - byte[7]=0: hold <= byte[6:0], hold_vld <= 1. A second type-1 byte overwrites the hold without error (resync).
  - byte[7]=1 with hold_vld=1: push {addr=byte[ADDR_W:1], data={byte[0],hold}} and clear hold_vld.
  - byte[7]=1 with hold_vld=0: set seq_err and discard the byte.
  - frame_err does not clear hold_vld.
- Latency: the FIFO write occurs on the `clk` edge of the stop-sample tick. wr_valid/wr_addr/wr_data are visible from the next cycle (first-word fall-through).
- FIFO:
  - Pop on `clk` edge when wr_valid & wr_ready.
  - Push with FIFO full and no pop in the same cycle: drop the pair and set ovf_err; contents are unchanged.
  - Push with FIFO full and a pop in the same cycle: accept the push; level is unchanged.
  - Simultaneous push and pop on an empty FIFO: no pop occurs (wr_valid=0), and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is exact, 0..FIFO_DEPTH.
  - wr_addr/wr_data are don't-care while wr_valid=0.
- Sticky flags: a set and `err_clr` in the same cycle leaves the flag set (set wins).
- rst_n asserted mid-frame: everything returns to reset values immediately. After release, the receiver waits for a fresh falling edge; a partial frame is never delivered.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Constants: DATA_BITS=8, WIRE_ADDR_W=6, FIRST_MARK=1'b0, SECOND_MARK=1'b1.
- Sub-module sync_fifo:
  - Parameters: WIDTH=ADDR_W+8, DEPTH.
  - Async active-low reset, FWFT.
  - Outputs: level, full, empty.
  - Instantiated once. The receiver FSM, pairing logic and error flags stay in uart_reg_rx.

Test Plan:
All cases use OVERSAMPLE=6, ADDR_W=6, FIFO_DEPTH=4, `uart_clk` high every cycle.
1. Send 0x25 then 0x8B, wr_ready=1 -> one beat, wr_addr=0x05, wr_data=0xA5; all error flags remain 0.
2. Send 0x25 with stop bit forced low, then 0x25, 0x8B -> frame_err=1; the following pair still delivers addr 0x05, data 0xA5. Pulse err_clr -> frame_err=0.
3. Send lone 0x81 -> seq_err=1, no FIFO push. Then send 0x7F, 0x81 -> addr 0x00, data 0xFF.
4. Hold wr_ready=0 and send 5 pairs (data 0x01..0x05, addr 1..5) -> fifo_level=4, ovf_err=1. Release wr_ready -> pops return 0x01..0x04 in order.
5. Drive rx low for 2 ticks then high -> no byte, no flags, FSM back in IDLE. Send a 12-bit-time break (rx low) -> frame_err=1, no push, receiver recovers for the next pair.
6. Assert rst_n low during DATA bit 4 of byte 2 -> all outputs 0 immediately. After release, a full pair 0x25, 0x8B delivers correctly and the pre-reset hold is not used.
